niosqs_timer_master: RTL and testbench

//  Avalon-MM initiator that programs and services the 16-bit-data interval-timer slave without CPU help.
//  On start it writes period and control, then handles each irq: clears status, snapshots the counter,

---
 rtl/niosqs_timer_master.sv | 183 ++++++++++++++++++
 tb/tb_niosqs_timer_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosqs_timer_master.sv
// Avalon-MM initiator that configures the interval timer, then services each timeout:
// clear status, snapshot the counter, read the snapshot back and count the event.
module niosqs_timer_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_load,
  input  logic        irq,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_read_n,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, ARMED, WR_CLR, WR_SNAP, RD_SL, RD_SH, WR_STOP
  } state_e;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_e      state_q, state_d;
  logic        wait_q, wait_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] period_q, period_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        snap_valid_q, snap_valid_d;
  logic        stop_pending_q, stop_pending_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        read_n_q, read_n_d;
  logic        write_n_q, write_n_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        accept;

  assign accept = cs_q && !m_waitrequest;

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    cnt_d          = cnt_q;
    lo_d           = lo_q;
    period_d       = period_q;
    tick_count_d   = tick_count_q;
    snapshot_d     = snapshot_q;
    snap_valid_d   = 1'b0;
    stop_pending_d = stop_pending_q;
    if (stop && state_q != IDLE && state_q != ARMED) stop_pending_d = 1'b1;

    case (state_q)
      IDLE: if (start) begin
        state_d        = WR_PL;
        tick_count_d   = '0;
        period_d       = period_load;
        stop_pending_d = stop;
      end
      WR_PL:   if (accept) state_d = WR_PH;
      WR_PH:   if (accept) state_d = WR_CTRL;
      WR_CTRL: if (accept) state_d = ARMED;
      ARMED: begin
        if (stop_pending_q || stop) state_d = WR_STOP;
        else if (irq)               state_d = WR_CLR;
      end
      WR_CLR:  if (accept) state_d = WR_SNAP;
      WR_SNAP: if (accept) state_d = RD_SL;
      // After the read is accepted the bus goes idle and cnt_q counts latency cycles.
      RD_SL: begin
        if (!wait_q) begin
          if (accept) begin
            wait_d = 1'b1;
            cnt_d  = 3'd1;
          end
        end else if (cnt_q == LAT) begin
          lo_d    = m_readdata;
          wait_d  = 1'b0;
          state_d = RD_SH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RD_SH: begin
        if (!wait_q) begin
          if (accept) begin
            wait_d = 1'b1;
            cnt_d  = 3'd1;
          end
        end else if (cnt_q == LAT) begin
          snapshot_d   = {m_readdata, lo_q};
          snap_valid_d = 1'b1;
          tick_count_d = tick_count_q + 32'd1;
          wait_d       = 1'b0;
          state_d      = ARMED;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR_STOP: if (accept) begin
        state_d        = IDLE;
        stop_pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered yet
    // present during the first cycle of each access.
    cs_d      = 1'b0;
    read_n_d  = 1'b1;
    write_n_d = 1'b1;
    addr_d    = '0;
    wdata_d   = '0;
    case (state_d)
      WR_PL:   begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
      WR_PH:   begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
      WR_CTRL: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007; end
      WR_CLR:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd0; end
      WR_SNAP: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd4; end
      RD_SL:   if (!wait_d) begin cs_d = 1'b1; read_n_d = 1'b0; addr_d = 3'd4; end
      RD_SH:   if (!wait_d) begin cs_d = 1'b1; read_n_d = 1'b0; addr_d = 3'd5; end
      WR_STOP: begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008; end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wait_q         <= 1'b0;
      cnt_q          <= '0;
      lo_q           <= '0;
      period_q       <= '0;
      tick_count_q   <= '0;
      snapshot_q     <= '0;
      snap_valid_q   <= 1'b0;
      stop_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      cs_q           <= 1'b0;
      read_n_q       <= 1'b1;
      write_n_q      <= 1'b1;
      addr_q         <= '0;
      wdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      cnt_q          <= cnt_d;
      lo_q           <= lo_d;
      period_q       <= period_d;
      tick_count_q   <= tick_count_d;
      snapshot_q     <= snapshot_d;
      snap_valid_q   <= snap_valid_d;
      stop_pending_q <= stop_pending_d;
      busy_q         <= busy_d;
      cs_q           <= cs_d;
      read_n_q       <= read_n_d;
      write_n_q      <= write_n_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
    end
  end

  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_read_n     = read_n_q;
  assign m_write_n    = write_n_q;
  assign m_writedata  = wdata_q;
  assign busy         = busy_q;
  assign tick_count   = tick_count_q;
  assign snapshot     = snapshot_q;
  assign snap_valid   = snap_valid_q;

endmodule

// File: tb/tb_niosqs_timer_master.sv
// Scoreboard bench for niosqs_timer_master with a behavioural timer slave per instance.
module tb_niosqs_timer_master;

  typedef struct packed {logic rd; logic [2:0] addr; logic [15:0] data;} acc_t;
  typedef struct packed {logic [31:0] snap; logic [31:0] tick;} snp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0;
  logic [31:0] period_load = '0;
  int checks = 0, errors = 0;

  // Instance 1: READ_LATENCY = 1
  logic [2:0] addr1; logic cs1, rn1, wn1, busy1, sv1; logic [15:0] wd1;
  logic [15:0] rdata1 = 16'hDEAD; logic wreq1 = 1'b0, to1 = 1'b0, fire1 = 1'b0;
  logic [31:0] tick1, snap1, sreg1 = '0, slave_cnt1 = '0;
  int stall_left = 0, stall_seen = 0;

  // Instance 3: READ_LATENCY = 3
  logic [2:0] addr3; logic cs3, rn3, wn3, busy3, sv3; logic [15:0] wd3;
  logic [15:0] p0 = 16'hDEAD, p1 = 16'hDEAD, p2 = 16'hDEAD;
  logic to3 = 1'b0, fire3 = 1'b0, start3 = 1'b0, stop3 = 1'b0, wreq3 = 1'b0;
  logic [31:0] tick3, snap3, sreg3 = '0, slave_cnt3 = '0;

  acc_t exp_q[$];
  snp_t snp_q[$], snp3_q[$];

  niosqs_timer_master #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .period_load(period_load),
    .irq(to1), .m_address(addr1), .m_chipselect(cs1), .m_read_n(rn1), .m_write_n(wn1),
    .m_writedata(wd1), .m_readdata(rdata1), .m_waitrequest(wreq1), .busy(busy1),
    .tick_count(tick1), .snapshot(snap1), .snap_valid(sv1));

  niosqs_timer_master #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .stop(stop3), .period_load(period_load),
    .irq(to3), .m_address(addr3), .m_chipselect(cs3), .m_read_n(rn3), .m_write_n(wn3),
    .m_writedata(wd3), .m_readdata(p2), .m_waitrequest(wreq3), .busy(busy3),
    .tick_count(tick3), .snapshot(snap3), .snap_valid(sv3));

  always #5 clk = ~clk;

  // Timer slave models: timeout flag cleared by a status write, snapshot latched by addr 4.
  always @(posedge clk) begin
    if (fire1) to1 <= 1'b1;
    else if (cs1 && !wreq1 && !wn1 && addr1 == 3'd0) to1 <= 1'b0;
    if (cs1 && !wreq1 && !wn1 && addr1 == 3'd4) sreg1 <= slave_cnt1;
    rdata1 <= (cs1 && !wreq1 && !rn1) ? ((addr1 == 3'd4) ? sreg1[15:0] : sreg1[31:16]) : 16'hDEAD;

    if (fire3) to3 <= 1'b1;
    else if (cs3 && !wn3 && addr3 == 3'd0) to3 <= 1'b0;
    if (cs3 && !wn3 && addr3 == 3'd4) sreg3 <= slave_cnt3;
    p0 <= (cs3 && !rn3) ? ((addr3 == 3'd4) ? sreg3[15:0] : sreg3[31:16]) : 16'hDEAD;
    p1 <= p0;
    p2 <= p1;
  end

  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && cs1 && !wn1 && addr1 == 3'd3) begin
      wreq1 = 1'b1;
      stall_left = stall_left - 1;
    end else begin
      wreq1 = 1'b0;
    end
  end

  // Monitor: compare accepted accesses and snapshot events against the queues.
  always @(negedge clk) begin
    acc_t ga, ea;
    snp_t gs, es;
    if (reset_n) begin
      if (cs1 && wreq1) begin
        stall_seen++;
        checks++;
        if (addr1 !== 3'd3 || wd1 !== 16'h0001 || wn1 !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: addr=%0d data=%h write_n=%b, need addr=3 data=0001 write_n=0", addr1, wd1, wn1);
        end
      end
      if (cs1 && !wreq1) begin
        ga = {~rn1, addr1, wd1};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: rd=%b addr=%0d data=%h, none expected", ga.rd, ga.addr, ga.data);
        end else begin
          ea = exp_q.pop_front();
          if (ga !== ea) begin
            errors++;
            $display("FAIL bus_access: got rd=%b addr=%0d data=%h, need rd=%b addr=%0d data=%h",
                     ga.rd, ga.addr, ga.data, ea.rd, ea.addr, ea.data);
          end
        end
      end
      if (sv1) begin
        gs = {snap1, tick1};
        checks++;
        if (snp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_snap: snapshot=%h tick=%h", gs.snap, gs.tick);
        end else begin
          es = snp_q.pop_front();
          if (gs !== es) begin
            errors++;
            $display("FAIL snapshot: got snap=%h tick=%h, need snap=%h tick=%h", gs.snap, gs.tick, es.snap, es.tick);
          end
        end
      end
      if (sv3) begin
        gs = {snap3, tick3};
        checks++;
        if (snp3_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_snap3: snapshot=%h tick=%h", gs.snap, gs.tick);
        end else begin
          es = snp3_q.pop_front();
          if (gs !== es) begin
            errors++;
            $display("FAIL snapshot_lat3: got snap=%h tick=%h, need snap=%h tick=%h", gs.snap, gs.tick, es.snap, es.tick);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic push_w(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic push_cfg(input logic [31:0] p);
    push_w(3'd2, p[15:0]);
    push_w(3'd3, p[31:16]);
    push_w(3'd1, 16'h0007);
  endtask

  task automatic push_service(input logic [31:0] cnt, input logic [31:0] tick);
    push_w(3'd0, 16'h0000);
    push_w(3'd4, 16'h0000);
    exp_q.push_back({1'b1, 3'd4, 16'h0000});
    exp_q.push_back({1'b1, 3'd5, 16'h0000});
    snp_q.push_back({cnt, tick});
  endtask

  task automatic pulse_start(input logic with_stop);
    @(posedge clk); #1 start = 1'b1; stop = with_stop;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic fire();
    @(posedge clk); #1 fire1 = 1'b1;
    @(posedge clk); #1 fire1 = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || snp_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_q.size() != 0 || snp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d accesses and %0d snapshots outstanding, need 0", name, exp_q.size(), snp_q.size());
      exp_q.delete(); snp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy1 && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    int n;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs1}, 32'd0);
    chk("rst_strobes", {30'd0, rn1, wn1}, 32'd3);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_tick", tick1, 32'd0);
    chk("rst_snap", {snap1[30:0], sv1}, 32'd0);
    chk("rst_addr_data", {13'd0, addr1, wd1}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: configuration writes on three consecutive cycles
    period_load = 32'h0001_86A0;
    push_cfg(period_load);
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cfg_consecutive", {30'd0, cs1, wn1}, 32'd2);
    end
    @(negedge clk);
    chk("armed_busy_idlebus", {30'd0, busy1, cs1}, 32'd2);
    wait_drained("cfg", 10);

    // 2: one service, irq-to-snap_valid latency of 7 cycles after irq rises
    slave_cnt1 = 32'h0000_1234;
    push_service(slave_cnt1, 32'd1);
    fire();
    n = 1;
    @(negedge clk);
    while (!sv1 && n < 30) begin
      @(negedge clk); n++;
    end
    chk("service_latency", n, 32'd8);
    wait_drained("service", 10);
    chk("tick_after_service", tick1, 32'd1);

    // 3: stall on the high period write
    push_w(3'd1, 16'h0008);
    pulse_stop();
    wait_idle("stop_idle", 20);
    wait_drained("stop", 5);
    stall_left = 3;
    stall_seen = 0;
    push_cfg(period_load);
    pulse_start(1'b0);
    wait_drained("stall_cfg", 20);
    chk("stall_cycles", stall_seen, 32'd3);
    chk("tick_cleared_on_start", tick1, 32'd0);

    // 4: stop during RD_SL defers until the service finishes
    slave_cnt1 = 32'hABCD_0042;
    push_service(slave_cnt1, 32'd1);
    push_w(3'd1, 16'h0008);
    fire();
    n = 0;
    while (!(cs1 && !rn1 && addr1 == 3'd4) && n < 20) begin
      @(negedge clk); n++;
    end
    chk("saw_rd_sl", {31'd0, (cs1 && !rn1 && addr1 == 3'd4)}, 32'd1);
    pulse_stop();
    wait_idle("stop_deferred_idle", 30);
    wait_drained("stop_deferred", 5);
    chk("tick_after_deferred_stop", tick1, 32'd1);

    // 5: tick_count wraps
    push_cfg(period_load);
    pulse_start(1'b0);
    wait_drained("cfg_wrap", 10);
    force dut1.tick_count_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut1.tick_count_q;
    slave_cnt1 = 32'h7654_3210;
    push_service(slave_cnt1, 32'd0);
    fire();
    wait_drained("wrap", 30);
    chk("tick_wrapped", tick1, 32'd0);

    // 5b: READ_LATENCY = 3 instance
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    repeat (6) @(negedge clk);
    slave_cnt3 = 32'h5A5A_C3C3;
    snp3_q.push_back({slave_cnt3, 32'd1});
    @(posedge clk); #1 fire3 = 1'b1;
    @(posedge clk); #1 fire3 = 1'b0;
    n = 0;
    while (snp3_q.size() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("lat3_drained", snp3_q.size(), 32'd0);

    // 6: reset during WR_CTRL aborts the bus at once
    push_w(3'd1, 16'h0008);
    pulse_stop();
    wait_idle("stop_before_reset", 20);
    wait_drained("stop_before_reset", 5);
    push_w(3'd2, period_load[15:0]);
    push_w(3'd3, period_load[31:16]);
    pulse_start(1'b0);
    n = 0;
    @(negedge clk);
    while (!(cs1 && !wn1 && addr1 == 3'd3) && n < 10) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("async_reset_bus", {29'd0, cs1, rn1, wn1}, 32'd3);
    chk("async_reset_busy", {31'd0, busy1}, 32'd0);
    wait_drained("pre_reset", 2);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_cfg(period_load);
    pulse_start(1'b0);
    wait_drained("cfg_after_reset", 10);
    slave_cnt1 = 32'h0000_FFFF;
    push_service(slave_cnt1, 32'd1);
    fire();
    wait_drained("service_after_reset", 30);

    // start and stop together in IDLE: configure, then stop immediately
    push_w(3'd1, 16'h0008);
    pulse_stop();
    wait_idle("stop_final", 20);
    wait_drained("stop_final", 5);
    push_cfg(32'h0000_0010);
    push_w(3'd1, 16'h0008);
    period_load = 32'h0000_0010;
    pulse_start(1'b1);
    wait_idle("start_stop_idle", 20);
    wait_drained("start_stop", 5);
    chk("start_stop_tick", tick1, 32'd0);

    repeat (5) @(negedge clk);
    chk("queues_empty", exp_q.size() + snp_q.size() + snp3_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
